mor1kx_muldiv_marocchino: RTL
=============================

Name: mor1kx_muldiv_marocchino

Overview:
- Parametrised multi-cycle integer multiply/divide unit for the MAROCCHINO execute stage.
- Generalises the fixed 32-bit 3-cycle multiplier and radix-2 divider. Adds:
  - configurable operand width, multiplier pipeline depth and divider radix
  - high-word multiply
  - remainder results
  - fast-path divide-by-zero and signed-overflow handling
- Sits beside the 1-clock ALU. Uses a start/ready and valid/ack handshake so the execute controller can stall or flush it.

Parameters:
- OPTION_OPERAND_WIDTH, 32: operand/result width W. Must be even and ≥8.
- MUL_STAGES, 2: multiplier register stages, 1..4.
- DIV_BITS_PER_CYCLE, 1: quotient bits resolved per iteration K, one of 1, 2, 4. K must divide W.
- FEATURE_MULH, "ENABLED": "NONE" makes MULHS/MULHU behave as invalid opcodes.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; abort any operation
- start_i  in  1  request; accepted when start_i & ready_o
- opc_i  in  3  opcode: 0 MUL, 1 MULHS, 2 MULHU, 3 DIVS, 4 DIVU, 5 REMS, 6 REMU, 7 invalid
- opa_i  in  W  operand A (multiplicand / dividend)
- opb_i  in  W  operand B (multiplier / divisor)
- ready_o  out  1  unit can accept a request this cycle
- valid_o  out  1  result_o / flags valid; held until ack_i
- ack_i  in  1  result consumed
- result_o  out  W  result
- ovf_o  out  1  signed div/rem by zero or MIN/−1; qualified by valid_o
- cy_o  out  1  unsigned div/rem by zero; qualified by valid_o

Behaviour:
- Reset (rst_n=0, async): state IDLE, ready_o=1, valid_o=0, result_o=0, ovf_o=0, cy_o=0, iteration counter 0, multiplier stage valids 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- ready_o = (state==IDLE) | (state==DONE & ack_i). This allows back-to-back issue.
- Operands and opcode are captured only on acceptance. Later input changes are ignored.

Transitions:
- IDLE/DONE → MUL on accepted opcode 0..2.
- IDLE/DONE → DIV on accepted opcode 3..6, normal case.
- IDLE/DONE → DONE on an accepted fast-path case or an invalid opcode.
- DONE → IDLE on ack_i without a new start.

Multiply:
- Full 2W product, signed or unsigned per opcode. MUL returns the low W bits; MUL is sign-agnostic.
- valid_o rises exactly MUL_STAGES+1 cycles after the acceptance edge. With MUL_STAGES=2 that is 3 cycles, matching the current unit.

Divide (normal path):
- Magnitudes are taken at acceptance for signed ops.
- Restoring division over W/K cycles, K bits per cycle.
- The FIX state (1 cycle) applies signs:
  - quotient is negated if the operand signs differ
  - remainder takes the dividend's sign
- valid_o rises W/K+2 cycles after acceptance (W=32, K=1: 34).

Fast paths (valid_o 1 cycle after acceptance, no iteration):
- Divisor 0: DIV* result all-ones; REM* result = opa. ovf_o=1 for signed, cy_o=1 for unsigned.
- DIVS/REMS with opa=MIN and opb=−1: DIVS result MIN, REMS result 0, ovf_o=1.
- Invalid opcode: result 0, flags 0, valid_o after 1 cycle.

Output holding and flags:
- In DONE, result_o/ovf_o/cy_o/valid_o are stable until ack_i. ack_i outside DONE is ignored.
- ovf_o and cy_o are 0 for all multiply ops.

Flush:
- flush_i has priority over everything, including start_i in the same cycle. The start is not accepted.
- Next cycle: state IDLE, valid_o=0, flags 0. Multiplier stage valids and the divider counter are cleared.
- result_o keeps its last value.

Other rules:
- Reset asserted mid-operation aborts immediately; the unit returns to reset values.
- ack_i and start_i together in DONE: the old result is retired and the new op is accepted. valid_o drops the next cycle, except for fast paths, where it stays 1 with the new result.

Test Plan:
- W=32, MUL_STAGES=2: MUL 0xFFFFFFFF×0x00000002 → result 0xFFFFFFFE, valid_o exactly 3 cycles after accept. MULHU same operands → 0x00000001. MULHS → 0xFFFFFFFF.
- DIVS −7/2 → 0xFFFFFFFD (−3), 34 cycles (K=1). REMS −7/2 → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2. Repeat with K=4: valid after 10 cycles, identical results.
- DIVU 5/0 → result 0xFFFFFFFF, cy_o=1, ovf_o=0, valid 1 cycle after accept. REMS 5/0 → result 5, ovf_o=1. DIVS 0x80000000/0xFFFFFFFF → 0x80000000, ovf_o=1.
- Back-to-back: hold ack_i=0 for 5 cycles after valid → result stable, ready_o=0. Then ack_i=1 with start_i=1 (MUL 3×4) in the same cycle → accepted, 12 delivered 3 cycles later.
- flush_i at divider cycle 10 with start_i=1 → next cycle IDLE, valid_o=0, start not accepted. A subsequent DIVU 9/3 → 3 with full latency.
- rst_n pulsed low mid-multiply → outputs immediately at reset values, ready_o=1. No stale valid_o after release.

Source files
------------

// File: rtl/mor1kx_muldiv_marocchino.sv
// Multi-cycle integer multiply/divide unit for the MAROCCHINO execute stage.
// Multiplier: operand capture register followed by MUL_STAGES-1 product
// registers, then the result register. Divider: restoring, K quotient bits
// per cycle, followed by a one-cycle sign-fix state. Division by zero and
// signed MIN/-1 finish directly without iterating.
module mor1kx_muldiv_marocchino #(
    parameter int    OPTION_OPERAND_WIDTH = 32,
    parameter int    MUL_STAGES           = 2,
    parameter int    DIV_BITS_PER_CYCLE   = 1,
    parameter string FEATURE_MULH         = "ENABLED"
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic                            start_i,
    input  logic [2:0]                      opc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] opa_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] opb_i,
    output logic                            ready_o,
    output logic                            valid_o,
    input  logic                            ack_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    output logic                            ovf_o,
    output logic                            cy_o
);

    localparam int W         = OPTION_OPERAND_WIDTH;
    localparam int K         = DIV_BITS_PER_CYCLE;
    localparam int DIV_ITERS = W / K;
    localparam int CNT_W     = $clog2(DIV_ITERS);
    localparam bit MULH_EN   = (FEATURE_MULH != "NONE");

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);
    localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0]     MIN_W    = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] OPC_MUL   = 3'd0;
    localparam logic [2:0] OPC_MULHS = 3'd1;
    localparam logic [2:0] OPC_MULHU = 3'd2;
    localparam logic [2:0] OPC_DIVS  = 3'd3;
    localparam logic [2:0] OPC_DIVU  = 3'd4;
    localparam logic [2:0] OPC_REMS  = 3'd5;
    localparam logic [2:0] OPC_REMU  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t state_r, state_next;

    logic [W-1:0] result_r, result_next;
    logic         valid_r;
    logic         ovf_r, ovf_next;
    logic         cy_r, cy_next;

    logic ready_s, accept_s;
    logic load_mul_s, load_div_s, div_step_s;

    // request decode
    logic         is_mul_s, is_div_s, div_signed_s, div_rem_s, b_zero_s;
    logic         fast_s, fast_ovf_s, fast_cy_s;
    logic [W-1:0] fast_res_s;
    logic [W-1:0] mag_a_s, mag_b_s;

    // multiplier
    logic [W-1:0]            mul_a_r, mul_b_r;
    logic                    mul_sgn_r, mul_hi_r;
    logic [MUL_STAGES-1:0]   mul_vld_r, mul_vld_next;
    logic [2*W-1:0]          prod_comb_s, prod_tail_s;

    // divider
    logic [W-1:0]     q_r, rem_r, dvs_r;
    logic             neg_q_r, neg_r_r, rem_op_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     q_step_s, rem_step_s;
    logic [W:0]       shl_s, diff_s;
    logic [W-1:0]     fix_res_s;

    assign ready_s  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & ack_i);
    assign accept_s = start_i & ready_s & ~flush_i;

    assign ready_o  = ready_s;
    assign valid_o  = valid_r;
    assign result_o = result_r;
    assign ovf_o    = ovf_r;
    assign cy_o     = cy_r;

    // Opcode classification and divider operand preparation for the incoming request
    always_comb begin
        is_mul_s     = (opc_i == OPC_MUL) |
                       (MULH_EN & ((opc_i == OPC_MULHS) | (opc_i == OPC_MULHU)));
        is_div_s     = (opc_i == OPC_DIVS) | (opc_i == OPC_DIVU) |
                       (opc_i == OPC_REMS) | (opc_i == OPC_REMU);
        div_signed_s = (opc_i == OPC_DIVS) | (opc_i == OPC_REMS);
        div_rem_s    = (opc_i == OPC_REMS) | (opc_i == OPC_REMU);
        b_zero_s     = (opb_i == ZERO_W);
        if (div_signed_s & opa_i[W-1]) begin
            mag_a_s = -opa_i;
        end else begin
            mag_a_s = opa_i;
        end
        if (div_signed_s & opb_i[W-1]) begin
            mag_b_s = -opb_i;
        end else begin
            mag_b_s = opb_i;
        end
    end

    // Requests that complete without iterating: invalid opcode, divide by zero, MIN/-1
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = ZERO_W;
        fast_ovf_s = 1'b0;
        fast_cy_s  = 1'b0;
        if (!is_mul_s && !is_div_s) begin
            fast_s = 1'b1;
        end else if (is_div_s && b_zero_s) begin
            fast_s     = 1'b1;
            fast_res_s = div_rem_s ? opa_i : ALL_ONES;
            fast_ovf_s = div_signed_s;
            fast_cy_s  = ~div_signed_s;
        end else if (is_div_s && div_signed_s && (opa_i == MIN_W) && (opb_i == ALL_ONES)) begin
            fast_s     = 1'b1;
            fast_res_s = div_rem_s ? ZERO_W : MIN_W;
            fast_ovf_s = 1'b1;
        end else begin
            fast_s = 1'b0;
        end
    end

    // Full-width product; MUL low word is sign-agnostic so only MULHS extends signs
    assign prod_comb_s = {{W{mul_sgn_r & mul_a_r[W-1]}}, mul_a_r} *
                         {{W{mul_sgn_r & mul_b_r[W-1]}}, mul_b_r};

    if (MUL_STAGES > 1) begin : g_mul_pipe
        logic [2*W-1:0] pipe_r [MUL_STAGES-1];

        // Product register chain between the operand registers and the result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < MUL_STAGES - 1; j++) begin
                    pipe_r[j] <= {(2*W){1'b0}};
                end
            end else begin
                pipe_r[0] <= prod_comb_s;
                for (int j = 1; j < MUL_STAGES - 1; j++) begin
                    pipe_r[j] <= pipe_r[j-1];
                end
            end
        end

        assign prod_tail_s = pipe_r[MUL_STAGES-2];
    end else begin : g_mul_comb
        assign prod_tail_s = prod_comb_s;
    end

    // Stage-valid shift register that tracks an operation through the multiplier
    always_comb begin
        mul_vld_next    = mul_vld_r << 1;
        mul_vld_next[0] = load_mul_s;
    end

    // K restoring steps of the divider; bit W of the difference is the borrow
    always_comb begin
        q_step_s   = q_r;
        rem_step_s = rem_r;
        shl_s      = {(W+1){1'b0}};
        diff_s     = {(W+1){1'b0}};
        for (int i = 0; i < K; i++) begin
            shl_s    = {rem_step_s, q_step_s[W-1]};
            diff_s   = shl_s - {1'b0, dvs_r};
            q_step_s = {q_step_s[W-2:0], ~diff_s[W]};
            if (diff_s[W]) begin
                rem_step_s = shl_s[W-1:0];
            end else begin
                rem_step_s = diff_s[W-1:0];
            end
        end
    end

    // Sign correction: quotient negated on differing signs, remainder follows the dividend
    always_comb begin
        if (rem_op_r) begin
            fix_res_s = neg_r_r ? -rem_r : rem_r;
        end else begin
            fix_res_s = neg_q_r ? -q_r : q_r;
        end
    end

    assign div_step_s = (state_r == ST_DIV) & ~flush_i;

    // Next-state, result and flag selection; flush overrides everything
    always_comb begin
        state_next  = state_r;
        result_next = result_r;
        ovf_next    = ovf_r;
        cy_next     = cy_r;
        load_mul_s  = 1'b0;
        load_div_s  = 1'b0;
        if (flush_i) begin
            state_next = ST_IDLE;
            ovf_next   = 1'b0;
            cy_next    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (fast_s) begin
                            state_next  = ST_DONE;
                            result_next = fast_res_s;
                            ovf_next    = fast_ovf_s;
                            cy_next     = fast_cy_s;
                        end else if (is_mul_s) begin
                            state_next = ST_MUL;
                            load_mul_s = 1'b1;
                            ovf_next   = 1'b0;
                            cy_next    = 1'b0;
                        end else begin
                            state_next = ST_DIV;
                            load_div_s = 1'b1;
                            ovf_next   = 1'b0;
                            cy_next    = 1'b0;
                        end
                    end else if ((state_r == ST_DONE) && ack_i) begin
                        state_next = ST_IDLE;
                        ovf_next   = 1'b0;
                        cy_next    = 1'b0;
                    end else begin
                        state_next = state_r;
                    end
                end
                ST_MUL: begin
                    if (mul_vld_r[MUL_STAGES-1]) begin
                        state_next  = ST_DONE;
                        result_next = mul_hi_r ? prod_tail_s[2*W-1:W] : prod_tail_s[W-1:0];
                    end else begin
                        state_next = ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (cnt_r == CNT_LAST) begin
                        state_next = ST_FIX;
                    end else begin
                        state_next = ST_DIV;
                    end
                end
                ST_FIX: begin
                    state_next  = ST_DONE;
                    result_next = fix_res_s;
                end
                default: begin
                    state_next = ST_IDLE;
                    ovf_next   = 1'b0;
                    cy_next    = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; valid_o mirrors residency in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            valid_r  <= 1'b0;
            result_r <= ZERO_W;
            ovf_r    <= 1'b0;
            cy_r     <= 1'b0;
        end else begin
            state_r  <= state_next;
            valid_r  <= (state_next == ST_DONE);
            result_r <= result_next;
            ovf_r    <= ovf_next;
            cy_r     <= cy_next;
        end
    end

    // Multiplier operand capture and stage-valid tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_r   <= ZERO_W;
            mul_b_r   <= ZERO_W;
            mul_sgn_r <= 1'b0;
            mul_hi_r  <= 1'b0;
            mul_vld_r <= {MUL_STAGES{1'b0}};
        end else begin
            if (flush_i) begin
                mul_vld_r <= {MUL_STAGES{1'b0}};
            end else begin
                mul_vld_r <= mul_vld_next;
            end
            if (load_mul_s) begin
                mul_a_r   <= opa_i;
                mul_b_r   <= opb_i;
                mul_sgn_r <= (opc_i == OPC_MULHS);
                mul_hi_r  <= (opc_i != OPC_MUL);
            end
        end
    end

    // Divider operand capture (magnitudes and result signs) and iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r      <= ZERO_W;
            rem_r    <= ZERO_W;
            dvs_r    <= ZERO_W;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            rem_op_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load_div_s) begin
            q_r      <= mag_a_s;
            rem_r    <= ZERO_W;
            dvs_r    <= mag_b_s;
            neg_q_r  <= div_signed_s & (opa_i[W-1] ^ opb_i[W-1]);
            neg_r_r  <= div_signed_s & opa_i[W-1];
            rem_op_r <= div_rem_s;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (div_step_s) begin
            q_r   <= q_step_s;
            rem_r <= rem_step_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule
